// File: rtl/cart_pkg.sv
// Shared types and constants for the MMC1 cart controller.
package cart_pkg;

    typedef enum logic [1:0] {
        MIR_ONE_LO = 2'd0,
        MIR_ONE_HI = 2'd1,
        MIR_VERT   = 2'd2,
        MIR_HORZ   = 2'd3
    } mirror_t;

    typedef enum logic [1:0] {
        PRG_32K_LO    = 2'd0,
        PRG_32K_HI    = 2'd1,
        PRG_FIX_FIRST = 2'd2,
        PRG_FIX_LAST  = 2'd3
    } prg_mode_t;

    typedef enum logic [1:0] {
        TGT_CTRL = 2'd0,
        TGT_CHR0 = 2'd1,
        TGT_CHR1 = 2'd2,
        TGT_PRG  = 2'd3
    } tgt_t;

    localparam logic [4:0] MMC1_SR_EMPTY = 5'b10000;
    localparam logic [4:0] MMC1_CTRL_RST = 5'h0C;

endpackage

// File: rtl/mmc1_serial_loader.sv
// MMC1 serial port: filters CPU write edges, shifts bits in LSB first and
// emits a one-cycle load (or clear) pulse when a register write completes.
module mmc1_serial_loader
    import cart_pkg::*;
(
    input  logic       clk_cpu,
    input  logic       rst,
    input  logic       romsel,
    input  logic       cpu_rw,
    input  logic [1:0] tgt_sel,
    input  logic       data_b7,
    input  logic       data_b0,
    output logic       clr,
    output logic       load,
    output logic [1:0] load_tgt,
    output logic [4:0] load_val
);

    logic       wr;
    logic       accept;
    logic       wr_d, wr_q;
    logic [4:0] sr_d, sr_q;

    assign wr     = romsel & ~cpu_rw;
    // Only the first cycle of back-to-back writes counts (RMW double write).
    assign accept = wr & ~wr_q;

    always_comb begin
        wr_d     = wr;
        sr_d     = sr_q;
        clr      = 1'b0;
        load     = 1'b0;
        load_tgt = tgt_sel;
        load_val = {data_b0, sr_q[4:1]};
        if (accept) begin
            if (data_b7) begin
                sr_d = MMC1_SR_EMPTY;
                clr  = 1'b1;
            end else if (sr_q[0]) begin
                // Marker bit reached the bottom: this is the fifth bit.
                sr_d = MMC1_SR_EMPTY;
                load = 1'b1;
            end else begin
                sr_d = {data_b0, sr_q[4:1]};
            end
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            wr_q <= 1'b0;
            sr_q <= MMC1_SR_EMPTY;
        end else begin
            wr_q <= wr_d;
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/cart_001_ctrl.sv
// MMC1 (mapper 1) bank controller: bank registers plus combinational
// PRG/CHR address banking, mirroring and PRG-RAM select.
module cart_001_ctrl
    import cart_pkg::*;
#(
    parameter int PRG_ROM_DEPTH = 18,
    parameter int CHR_ROM_DEPTH = 17,
    parameter int PRG_RAM_DEPTH = 13
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic [14:0]              cpu_addr,
    input  logic [7:0]               cpu_data_i,
    input  logic                     cpu_rw,
    input  logic                     romsel,
    input  logic [13:0]              ppu_addr,
    output logic [PRG_ROM_DEPTH-1:0] prg_rom_addr,
    output logic                     prg_rom_cs,
    output logic [PRG_RAM_DEPTH-1:0] prg_ram_addr,
    output logic                     prg_ram_cs,
    output logic [CHR_ROM_DEPTH-1:0] chr_addr,
    output logic                     chr_cs,
    output logic                     ciram_ce,
    output logic                     ciram_a10,
    output logic                     irq
);

    logic       ld_clr;
    logic       ld_load;
    logic [1:0] ld_tgt;
    logic [4:0] ld_val;
    logic       unused_data;

    logic [4:0] control_d, control_q;
    logic [4:0] chr0_d, chr0_q;
    logic [4:0] chr1_d, chr1_q;
    logic [4:0] prg_d, prg_q;

    logic [3:0]  prg_bank;
    logic [17:0] prg_full;
    logic [16:0] chr_full;

    assign unused_data = ^cpu_data_i[6:1];

    mmc1_serial_loader u_loader (
        .clk_cpu  (clk_cpu),
        .rst      (rst),
        .romsel   (romsel),
        .cpu_rw   (cpu_rw),
        .tgt_sel  (cpu_addr[14:13]),
        .data_b7  (cpu_data_i[7]),
        .data_b0  (cpu_data_i[0]),
        .clr      (ld_clr),
        .load     (ld_load),
        .load_tgt (ld_tgt),
        .load_val (ld_val)
    );

    always_comb begin
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        if (ld_clr) begin
            control_d[3:2] = 2'b11;
        end else if (ld_load) begin
            case (tgt_t'(ld_tgt))
                TGT_CTRL: control_d = ld_val;
                TGT_CHR0: chr0_d    = ld_val;
                TGT_CHR1: chr1_d    = ld_val;
                default:  prg_d     = ld_val;
            endcase
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            control_q <= MMC1_CTRL_RST;
            chr0_q    <= '0;
            chr1_q    <= '0;
            prg_q     <= '0;
        end else begin
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
        end
    end

    // Bank 4'hF truncates to the last bank for any supported ROM size.
    always_comb begin
        prg_bank = 4'd0;
        case (prg_mode_t'(control_q[3:2]))
            PRG_32K_LO, PRG_32K_HI: prg_bank = {prg_q[3:1], cpu_addr[14]};
            PRG_FIX_FIRST:          prg_bank = cpu_addr[14] ? prg_q[3:0] : 4'd0;
            default:                prg_bank = cpu_addr[14] ? 4'hF : prg_q[3:0];
        endcase
        prg_full = {prg_bank, cpu_addr[13:0]};
    end

    always_comb begin
        if (control_q[4])
            chr_full = {(ppu_addr[12] ? chr1_q : chr0_q), ppu_addr[11:0]};
        else
            chr_full = {chr0_q[4:1], ppu_addr[12:0]};
    end

    always_comb begin
        ciram_a10 = 1'b0;
        case (mirror_t'(control_q[1:0]))
            MIR_ONE_LO: ciram_a10 = 1'b0;
            MIR_ONE_HI: ciram_a10 = 1'b1;
            MIR_VERT:   ciram_a10 = ppu_addr[10];
            default:    ciram_a10 = ppu_addr[11];
        endcase
    end

    assign prg_rom_addr = prg_full[PRG_ROM_DEPTH-1:0];
    assign prg_rom_cs   = romsel;
    assign prg_ram_addr = cpu_addr[PRG_RAM_DEPTH-1:0];
    assign prg_ram_cs   = ~romsel & (cpu_addr[14:13] == 2'b11) & ~prg_q[4];
    assign chr_addr     = chr_full[CHR_ROM_DEPTH-1:0];
    assign chr_cs       = ~ppu_addr[13];
    assign ciram_ce     = ppu_addr[13];
    assign irq          = 1'b0;

endmodule

// File: tb/tb_cart_001_ctrl.sv
// Directed self-checking bench for the MMC1 cart controller.
module tb_cart_001_ctrl;

    logic        clk_cpu = 1'b0;
    logic        rst;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_i;
    logic        cpu_rw;
    logic        romsel;
    logic [13:0] ppu_addr;
    logic [17:0] prg_rom_addr;
    logic        prg_rom_cs;
    logic [12:0] prg_ram_addr;
    logic        prg_ram_cs;
    logic [16:0] chr_addr;
    logic        chr_cs;
    logic        ciram_ce;
    logic        ciram_a10;
    logic        irq;

    int passed = 0;
    int total  = 0;

    cart_001_ctrl dut (
        .clk_cpu      (clk_cpu),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_data_i   (cpu_data_i),
        .cpu_rw       (cpu_rw),
        .romsel       (romsel),
        .ppu_addr     (ppu_addr),
        .prg_rom_addr (prg_rom_addr),
        .prg_rom_cs   (prg_rom_cs),
        .prg_ram_addr (prg_ram_addr),
        .prg_ram_cs   (prg_ram_cs),
        .chr_addr     (chr_addr),
        .chr_cs       (chr_cs),
        .ciram_ce     (ciram_ce),
        .ciram_a10    (ciram_a10),
        .irq          (irq)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic idle_bus();
        romsel = 1'b0;
        cpu_rw = 1'b1;
    endtask

    // One accepted write: active for a single edge, then idle for one edge.
    task automatic wr_byte(input logic [14:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data_i = d; romsel = 1'b1; cpu_rw = 1'b0;
        @(posedge clk_cpu); #1;
        idle_bus();
        @(posedge clk_cpu); #1;
    endtask

    task automatic serial_load(input logic [14:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) wr_byte(a, {7'd0, v[i]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        repeat (2) @(posedge clk_cpu);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cpu_addr = 15'h4000; romsel = 1'b1; cpu_rw = 1'b1; ppu_addr = 14'h1ABC;
        #1;
        total++; if (prg_rom_addr !== 18'h3C000) $display("FAIL reset_prg: got %h want 3c000", prg_rom_addr); else passed++;
        total++; if (prg_rom_cs !== 1'b1) $display("FAIL reset_prg_cs: got %b want 1", prg_rom_cs); else passed++;
        total++; if (ciram_a10 !== 1'b0) $display("FAIL reset_a10: got %b want 0", ciram_a10); else passed++;
        total++; if (chr_addr !== 17'h01ABC) $display("FAIL reset_chr: got %h want 01abc", chr_addr); else passed++;
        total++; if ({chr_cs, ciram_ce, irq} !== 3'b100) $display("FAIL reset_sel: got %b want 100", {chr_cs, ciram_ce, irq}); else passed++;
        idle_bus();
        @(posedge clk_cpu); #1;
    endtask

    task automatic test_prg_load();
        serial_load(15'h6000, 5'h05);
        cpu_addr = 15'h0000; #1;
        total++; if (prg_rom_addr !== 18'h14000) $display("FAIL prg_load: got %h want 14000", prg_rom_addr); else passed++;
        cpu_addr = 15'h4000; #1;
        total++; if (prg_rom_addr !== 18'h3C000) $display("FAIL prg_last: got %h want 3c000", prg_rom_addr); else passed++;
    endtask

    task automatic test_sr_restart();
        wr_byte(15'h0000, 8'h01);
        wr_byte(15'h0000, 8'h01);
        wr_byte(15'h0000, 8'h80);
        serial_load(15'h0000, 5'h1F);
        ppu_addr = 14'h2800; #1;
        total++; if (ciram_a10 !== 1'b1) $display("FAIL horz_a10_hi: got %b want 1", ciram_a10); else passed++;
        ppu_addr = 14'h2400; #1;
        total++; if (ciram_a10 !== 1'b0) $display("FAIL horz_a10_lo: got %b want 0", ciram_a10); else passed++;
        ppu_addr = 14'h1234; #1;
        total++; if (chr_addr !== 17'h00234) $display("FAIL chr4k_zero: got %h want 00234", chr_addr); else passed++;
    endtask

    task automatic test_chr();
        serial_load(15'h2000, 5'd3);
        serial_load(15'h4000, 5'd9);
        ppu_addr = 14'h1234; #1;
        total++; if (chr_addr !== 17'h09234) $display("FAIL chr4k_hi: got %h want 09234", chr_addr); else passed++;
        ppu_addr = 14'h0234; #1;
        total++; if (chr_addr !== 17'h03234) $display("FAIL chr4k_lo: got %h want 03234", chr_addr); else passed++;
        serial_load(15'h0000, 5'h0F);
        ppu_addr = 14'h1234; #1;
        total++; if (chr_addr !== 17'h03234) $display("FAIL chr8k: got %h want 03234", chr_addr); else passed++;
    endtask

    task automatic test_mirror();
        serial_load(15'h0000, 5'h0E);
        ppu_addr = 14'h2400; #1;
        total++; if (ciram_a10 !== 1'b1) $display("FAIL vert_hi: got %b want 1", ciram_a10); else passed++;
        total++; if ({chr_cs, ciram_ce} !== 2'b01) $display("FAIL nt_sel: got %b want 01", {chr_cs, ciram_ce}); else passed++;
        ppu_addr = 14'h2800; #1;
        total++; if (ciram_a10 !== 1'b0) $display("FAIL vert_lo: got %b want 0", ciram_a10); else passed++;
        serial_load(15'h0000, 5'h0D);
        ppu_addr = 14'h2000; #1;
        total++; if (ciram_a10 !== 1'b1) $display("FAIL one_hi: got %b want 1", ciram_a10); else passed++;
        serial_load(15'h0000, 5'h0C);
        ppu_addr = 14'h2C00; #1;
        total++; if (ciram_a10 !== 1'b0) $display("FAIL one_lo: got %b want 0", ciram_a10); else passed++;
    endtask

    task automatic test_prg_modes();
        serial_load(15'h0000, 5'h08);
        cpu_addr = 15'h0123; #1;
        total++; if (prg_rom_addr !== 18'h00123) $display("FAIL mode2_lo: got %h want 00123", prg_rom_addr); else passed++;
        cpu_addr = 15'h4000; #1;
        total++; if (prg_rom_addr !== 18'h14000) $display("FAIL mode2_hi: got %h want 14000", prg_rom_addr); else passed++;
        serial_load(15'h0000, 5'h02);
        cpu_addr = 15'h4123; #1;
        total++; if (prg_rom_addr !== 18'h14123) $display("FAIL mode0_hi: got %h want 14123", prg_rom_addr); else passed++;
        cpu_addr = 15'h0123; #1;
        total++; if (prg_rom_addr !== 18'h10123) $display("FAIL mode0_lo: got %h want 10123", prg_rom_addr); else passed++;
        wr_byte(15'h0000, 8'h80);
        cpu_addr = 15'h4000; #1;
        total++; if (prg_rom_addr !== 18'h3C000) $display("FAIL clr_mode: got %h want 3c000", prg_rom_addr); else passed++;
        ppu_addr = 14'h2400; #1;
        total++; if (ciram_a10 !== 1'b1) $display("FAIL clr_keeps_mir: got %b want 1", ciram_a10); else passed++;
    endtask

    task automatic test_prg_ram();
        serial_load(15'h6000, 5'h10);
        cpu_addr = 15'h6000; romsel = 1'b0; #1;
        total++; if (prg_ram_cs !== 1'b0) $display("FAIL ram_disabled: got %b want 0", prg_ram_cs); else passed++;
        serial_load(15'h6000, 5'h00);
        cpu_addr = 15'h7ABC; romsel = 1'b0; #1;
        total++; if (prg_ram_cs !== 1'b1) $display("FAIL ram_enabled: got %b want 1", prg_ram_cs); else passed++;
        total++; if (prg_ram_addr !== 13'h1ABC) $display("FAIL ram_addr: got %h want 1abc", prg_ram_addr); else passed++;
        cpu_addr = 15'h4000; #1;
        total++; if (prg_ram_cs !== 1'b0) $display("FAIL ram_other_addr: got %b want 0", prg_ram_cs); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Write held active for two consecutive edges: only one bit enters.
        cpu_addr = 15'h6000; cpu_data_i = 8'h01; romsel = 1'b1; cpu_rw = 1'b0;
        repeat (2) @(posedge clk_cpu);
        #1 idle_bus();
        @(posedge clk_cpu); #1;
        wr_byte(15'h6000, 8'h00);
        wr_byte(15'h6000, 8'h01);
        wr_byte(15'h6000, 8'h00);
        wr_byte(15'h6000, 8'h00);
        cpu_addr = 15'h0000; #1;
        total++; if (prg_rom_addr !== 18'h14000) $display("FAIL rmw_filter: got %h want 14000", prg_rom_addr); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        wr_byte(15'h6000, 8'h01);
        wr_byte(15'h6000, 8'h01);
        // Write asserted during reset must be ignored as well.
        rst = 1'b1;
        cpu_addr = 15'h6000; cpu_data_i = 8'h01; romsel = 1'b1; cpu_rw = 1'b0;
        repeat (2) @(posedge clk_cpu);
        #1 rst = 1'b0; idle_bus();
        @(posedge clk_cpu); #1;
        cpu_addr = 15'h0000; #1;
        total++; if (prg_rom_addr !== 18'h00000) $display("FAIL mid_reset_prg: got %h want 00000", prg_rom_addr); else passed++;
        serial_load(15'h6000, 5'h05);
        cpu_addr = 15'h0000; #1;
        total++; if (prg_rom_addr !== 18'h14000) $display("FAIL mid_reset_load: got %h want 14000", prg_rom_addr); else passed++;
    endtask

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_data_i = '0; cpu_rw = 1'b1; romsel = 1'b0; ppu_addr = '0;
        test_reset();
        test_prg_load();
        test_sr_restart();
        test_chr();
        test_mirror();
        test_prg_modes();
        test_prg_ram();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
